dmem_port_arbiter: RTL and testbench

Shares the single data-memory write/read port between the store buffer drain side and the load-miss path of the MEM stage. Grants one requester at a time, holds the grant until the memory acknowledges, and prevents either side from starving. Supports a drain command (fence or `clear`) that forces the store buffer to empty before any further load is granted.

---
 rtl/mem_arb_pkg.sv | 6 +
 rtl/sat_counter.sv | 19 +
 rtl/dmem_port_arbiter.sv | 88 ++++++++
 tb/tb_dmem_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: arbiter state encoding and memory write-enable constants
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, STORE, DRAIN_WAIT} arb_state_e;
  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that saturates at LIMIT, with synchronous clear taking priority
module sat_counter #(
  parameter int W     = 3,
  parameter int LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);
  localparam logic [W-1:0] LIM = W'(LIMIT);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != LIM) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the data-memory port between store-buffer drain and load misses
module dmem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_BITS    = 32,
  parameter int ADDRESS_BITS = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_BITS     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ldReq,
  input  logic [ADDRESS_BITS-1:0] ldAddr,
  output logic [DATA_BITS-1:0]    ldData,
  output logic                    ldAck,
  input  logic                    stbReq,
  input  logic [ADDRESS_BITS-1:0] stbAddr,
  input  logic [DATA_BITS-1:0]    stbData,
  output logic                    stbAck,
  input  logic                    drainReq,
  output logic                    drainDone,
  output logic                    memReq,
  output logic                    memWe,
  output logic [ADDRESS_BITS-1:0] memAddr,
  output logic [DATA_BITS-1:0]    memWData,
  input  logic [DATA_BITS-1:0]    memRData,
  input  logic                    memAck
);
  localparam logic [CNT_BITS-1:0] STARVE_MAX = CNT_BITS'(STARVE_LIMIT);
  arb_state_e state_q;
  logic mem_req_q, mem_we_q, drained_q, drained_d;
  logic [ADDRESS_BITS-1:0] mem_addr_q;
  logic [DATA_BITS-1:0] mem_wdata_q;
  logic [CNT_BITS-1:0] starve_cnt;
  logic idle, starved, grant_ld, grant_st;
  // drained_q keeps drainDone to a single pulse per drain; any store granted meanwhile re-arms it
  always_comb begin
    idle      = state_q == IDLE;
    starved   = stbReq && starve_cnt == STARVE_MAX;
    grant_st  = idle && stbReq && (drainReq || starved || !ldReq);
    grant_ld  = idle && !drainReq && ldReq && !starved;
    ldAck     = state_q == LOAD && memAck;
    stbAck    = state_q == STORE && memAck;
    ldData    = ldAck ? memRData : '0;
    drainDone = idle && drainReq && !stbReq && !drained_q;
    drained_d = drainReq && (drainDone || (drained_q && !grant_st));
  end
  sat_counter #(.W(CNT_BITS), .LIMIT(STARVE_LIMIT)) u_starve (
    .clk   (clk),
    .rst_n (rst),
    .inc_i (ldAck && stbReq),
    .clr_i (stbAck || (idle && !stbReq)),
    .cnt_o (starve_cnt)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= MEM_RD;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      drained_q   <= 1'b0;
    end else begin
      drained_q <= drained_d;
      case (state_q)
        IDLE: if (grant_st || grant_ld) begin
          state_q     <= grant_st ? STORE : LOAD;
          mem_req_q   <= 1'b1;
          mem_we_q    <= grant_st ? MEM_WR : MEM_RD;
          mem_addr_q  <= grant_st ? stbAddr : ldAddr;
          mem_wdata_q <= grant_st ? stbData : '0;
        end
        LOAD, STORE: if (memAck) begin
          state_q     <= (state_q == STORE && drainReq) ? DRAIN_WAIT : IDLE;
          mem_req_q   <= 1'b0;
          mem_we_q    <= MEM_RD;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign memReq   = mem_req_q;
  assign memWe    = mem_we_q;
  assign memAddr  = mem_addr_q;
  assign memWData = mem_wdata_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed scenarios plus a randomized run against a transaction-level model
module tb_dmem_port_arbiter;
  localparam int D = 32, A = 32, LIM = 4;
  logic clk = 0, rst = 0;
  logic ldReq = 0, stbReq = 0, drainReq = 0, memAck = 0;
  logic [A-1:0] ldAddr = '0, stbAddr = '0;
  logic [D-1:0] stbData = '0, memRData = '0;
  logic [D-1:0] ldData, memWData;
  logic [A-1:0] memAddr;
  logic ldAck, stbAck, drainDone, memReq, memWe;
  int tests = 0, fails = 0;

  dmem_port_arbiter #(.DATA_BITS(D), .ADDRESS_BITS(A), .STARVE_LIMIT(LIM), .CNT_BITS(3)) dut (
    .clk(clk), .rst(rst), .ldReq(ldReq), .ldAddr(ldAddr), .ldData(ldData), .ldAck(ldAck),
    .stbReq(stbReq), .stbAddr(stbAddr), .stbData(stbData), .stbAck(stbAck),
    .drainReq(drainReq), .drainDone(drainDone), .memReq(memReq), .memWe(memWe),
    .memAddr(memAddr), .memWData(memWData), .memRData(memRData), .memAck(memAck)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({memReq, memWe, ldAck, stbAck, drainDone} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl got %b exp 00000", {memReq, memWe, ldAck, stbAck, drainDone});
    end
    tests++;
    if ({memAddr, memWData, ldData} !== '0) begin
      fails++; $display("FAIL reset_data got %h/%h/%h exp 0", memAddr, memWData, ldData);
    end
    @(negedge clk) rst = 1;
    tick;
  endtask

  task automatic test_lone_load;
    ldReq = 1; ldAddr = 32'h100;
    tick;
    tests++;
    if ({memReq, memWe, memAddr} !== {1'b1, 1'b0, 32'h100}) begin
      fails++; $display("FAIL load_grant got req=%b we=%b addr=%h exp 1/0/100", memReq, memWe, memAddr);
    end
    tick; tick;
    memAck = 1; memRData = 32'hDEADBEEF;
    #1;
    tests++;
    if ({ldAck, stbAck, ldData} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
      fails++; $display("FAIL load_ack got ld=%b st=%b data=%h exp 1/0/deadbeef", ldAck, stbAck, ldData);
    end
    tick;
    memAck = 0; ldReq = 0;
    #1;
    tests++;
    if ({ldAck, memReq} !== 2'b00) begin
      fails++; $display("FAIL load_done got ack=%b req=%b exp 0/0", ldAck, memReq);
    end
    tick;
  endtask

  task automatic test_simultaneous;
    ldReq = 1; ldAddr = 32'h300; stbReq = 1; stbAddr = 32'h200; stbData = 32'h11;
    tick;
    tests++;
    if ({memReq, memWe, memAddr} !== {1'b1, 1'b0, 32'h300}) begin
      fails++; $display("FAIL simul_first got req=%b we=%b addr=%h exp 1/0/300", memReq, memWe, memAddr);
    end
    memAck = 1;
    tick;
    memAck = 0; ldReq = 0;
    tests++;
    if (memReq !== 1'b0) begin
      fails++; $display("FAIL simul_bubble got req=%b exp 0", memReq);
    end
    tick;
    tests++;
    if ({memReq, memWe, memAddr, memWData} !== {1'b1, 1'b1, 32'h200, 32'h11}) begin
      fails++; $display("FAIL simul_store got req=%b we=%b addr=%h data=%h exp 1/1/200/11", memReq, memWe, memAddr, memWData);
    end
    memAck = 1;
    #1;
    tests++;
    if ({stbAck, ldAck} !== 2'b10) begin
      fails++; $display("FAIL simul_stback got st=%b ld=%b exp 1/0", stbAck, ldAck);
    end
    tick;
    memAck = 0; stbReq = 0;
    tick;
  endtask

  task automatic test_starvation;
    int loads = 0;
    bit got_store = 0;
    ldReq = 1; ldAddr = 32'h700; stbReq = 1; stbAddr = 32'h400; stbData = 32'h44;
    for (int i = 0; i < 12 && !got_store; i++) begin
      tick;
      if (memReq && memWe) got_store = 1;
      else if (memReq) loads++;
      memAck = 1;
      tick;
      memAck = 0;
    end
    tests++;
    if (loads !== LIM || !got_store) begin
      fails++; $display("FAIL starve_count got loads=%0d store=%0d exp %0d/1", loads, got_store, LIM);
    end
    tick;
    tests++;
    if ({memReq, memWe} !== 2'b10) begin
      fails++; $display("FAIL starve_reset got req=%b we=%b exp 1/0", memReq, memWe);
    end
    memAck = 1;
    tick;
    memAck = 0; ldReq = 0; stbReq = 0;
    tick;
  endtask

  task automatic test_drain;
    int n = 3, st_acks = 0, dd = 0, early = 0, late = 0;
    ldReq = 1; ldAddr = 32'h800; drainReq = 1;
    for (int i = 0; i < 60 && late == 0; i++) begin
      stbReq = n > 0; stbAddr = 32'h500 + 4 * n; stbData = n; memAck = memReq;
      #1;
      if (stbAck) begin st_acks++; n--; end
      if (ldAck) begin if (dd == 0) early++; else late++; end
      if (drainDone) dd++;
      tick;
      if (dd > 0) drainReq = 0;
    end
    tests++;
    if (st_acks !== 3) begin
      fails++; $display("FAIL drain_stores got %0d exp 3", st_acks);
    end
    tests++;
    if (dd !== 1) begin
      fails++; $display("FAIL drain_done got %0d exp 1", dd);
    end
    tests++;
    if ({early, late} !== {32'd0, 32'd1}) begin
      fails++; $display("FAIL drain_loads got early=%0d late=%0d exp 0/1", early, late);
    end
    ldReq = 0; memAck = 0; drainReq = 0;
    tick;
  endtask

  task automatic test_reset_mid_store;
    stbReq = 1; stbAddr = 32'h600; stbData = 32'h66;
    tick;
    tests++;
    if ({memReq, memWe} !== 2'b11) begin
      fails++; $display("FAIL rst_store_grant got req=%b we=%b exp 1/1", memReq, memWe);
    end
    memAck = 1;
    #2 rst = 0;
    #1;
    tests++;
    if ({memReq, stbAck, ldAck} !== 3'b000) begin
      fails++; $display("FAIL rst_async got req=%b st=%b ld=%b exp 000", memReq, stbAck, ldAck);
    end
    stbReq = 0; memAck = 0;
    @(negedge clk) rst = 1;
    tick;
    ldReq = 1; ldAddr = 32'h900;
    tick;
    tests++;
    if ({memReq, memWe, memAddr} !== {1'b1, 1'b0, 32'h900}) begin
      fails++; $display("FAIL rst_recover got req=%b we=%b addr=%h exp 1/0/900", memReq, memWe, memAddr);
    end
    memAck = 1;
    tick;
    memAck = 0; ldReq = 0;
    tick;
  endtask

  task automatic test_spurious_ack;
    memAck = 1;
    #1;
    tests++;
    if ({ldAck, stbAck, drainDone} !== 3'b000) begin
      fails++; $display("FAIL spurious_ack got ld=%b st=%b dd=%b exp 000", ldAck, stbAck, drainDone);
    end
    tick;
    memAck = 0; ldReq = 1; ldAddr = 32'hA00;
    tick;
    tests++;
    if ({memReq, memWe, memAddr} !== {1'b1, 1'b0, 32'hA00}) begin
      fails++; $display("FAIL spurious_idle got req=%b we=%b addr=%h exp 1/0/a00", memReq, memWe, memAddr);
    end
    memAck = 1;
    tick;
    memAck = 0; ldReq = 0;
    tick;
  endtask

  // Model: who owns the port (0 none, 1 load, 2 store), a post-drain settle cycle,
  // and how many loads have finished ahead of a waiting store.
  task automatic test_random;
    int owner, settle, waited, lat;
    bit ld_p, st_p, dr, reported, ack, e_ld, e_st, e_dd;
    logic [A-1:0] la, sa, xa;
    logic [D-1:0] sd, xd, rd;
    owner = 0; settle = 0; waited = 0; lat = 0;
    ld_p = 0; st_p = 0; dr = 0; reported = 0;
    la = '0; sa = '0; sd = '0; xa = '0; xd = '0;
    for (int c = 0; c < 600; c++) begin
      if (!ld_p && $urandom_range(0, 2) == 0) begin ld_p = 1; la = $urandom; end
      if (!st_p && $urandom_range(0, 2) == 0) begin st_p = 1; sa = $urandom; sd = $urandom; end
      if ($urandom_range(0, 15) == 0) dr = !dr;
      ldReq = ld_p; ldAddr = ld_p ? la : $urandom;
      stbReq = st_p; stbAddr = st_p ? sa : $urandom; stbData = st_p ? sd : $urandom;
      drainReq = dr;
      ack = owner != 0 ? lat == 0 : $urandom_range(0, 9) == 0;
      rd = $urandom;
      memAck = ack; memRData = rd;
      #1;
      e_ld = owner == 1 && ack;
      e_st = owner == 2 && ack;
      e_dd = owner == 0 && settle == 0 && dr && !st_p && !reported;
      tests++;
      if ({memReq, memWe} !== {owner != 0, owner == 2}) begin
        fails++; $display("FAIL rnd_req c=%0d got req=%b we=%b exp %b/%b", c, memReq, memWe, owner != 0, owner == 2);
      end
      tests++;
      if (memAddr !== (owner != 0 ? xa : '0)) begin
        fails++; $display("FAIL rnd_addr c=%0d got %h exp %h", c, memAddr, owner != 0 ? xa : '0);
      end
      if (owner != 1) begin
        tests++;
        if (memWData !== (owner == 2 ? xd : '0)) begin
          fails++; $display("FAIL rnd_wdata c=%0d got %h exp %h", c, memWData, owner == 2 ? xd : '0);
        end
      end
      tests++;
      if ({ldAck, stbAck, drainDone} !== {e_ld, e_st, e_dd}) begin
        fails++; $display("FAIL rnd_acks c=%0d got %b%b%b exp %b%b%b", c, ldAck, stbAck, drainDone, e_ld, e_st, e_dd);
      end
      tests++;
      if (ldData !== (e_ld ? rd : '0)) begin
        fails++; $display("FAIL rnd_ldata c=%0d got %h exp %h", c, ldData, e_ld ? rd : '0);
      end
      if (owner != 0) begin
        if (ack) begin
          if (owner == 1) begin
            if (st_p && waited < LIM) waited++;
            ld_p = 0;
          end else begin
            waited = 0; st_p = 0; settle = dr;
          end
          owner = 0;
        end else lat--;
      end else if (settle != 0) settle = 0;
      else begin
        if (dr && !st_p) reported = 1;
        if (dr) owner = st_p ? 2 : 0;
        else if (st_p && waited == LIM) owner = 2;
        else if (ld_p) owner = 1;
        else if (st_p) owner = 2;
        if (!st_p) waited = 0;
        if (owner != 0) begin
          xa = owner == 2 ? sa : la; xd = sd; lat = $urandom_range(0, 3);
          if (owner == 2) reported = 0;
        end
      end
      if (!dr) reported = 0;
      tick;
    end
    ldReq = 0; stbReq = 0; drainReq = 0; memAck = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_lone_load;
    test_simultaneous;
    test_starvation;
    test_drain;
    test_reset_mid_store;
    test_spurious_ack;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
